// File: rtl/victory_detect.sv
// rtl/victory_detect.sv - tug-of-war win detector with latched winner and HEX digit
// Optional VICTORY_SCORE_EN adds next-round pulse and saturating win tallies.
module victory_detect (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       NL,
  input  logic       NR,
`ifdef VICTORY_SCORE_EN
  input  logic       rnd,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
`endif
  output logic [6:0] disp,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    LWIN = 2'b01,
    RWIN = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= PLAY;
    end else begin
      r_state <= w_next;
    end
  end

  // A press only wins when the rope already sits at that player's edge;
  // simultaneous presses cancel.
  always_comb begin
    w_next = r_state;
    case (r_state)
      PLAY: begin
        if (L && !R && NL) begin
          w_next = LWIN;
        end else if (R && !L && NR) begin
          w_next = RWIN;
        end
      end
      LWIN, RWIN: begin
`ifdef VICTORY_SCORE_EN
        if (rnd) begin
          w_next = PLAY;
        end
`endif
      end
      default: w_next = PLAY;
    endcase
  end

  always_comb begin
    disp      = 7'b1111111;
    game_over = 1'b0;
    winner    = 2'b00;
    case (r_state)
      LWIN: begin
        disp      = 7'b1111001;
        game_over = 1'b1;
        winner    = 2'b01;
      end
      RWIN: begin
        disp      = 7'b0100100;
        game_over = 1'b1;
        winner    = 2'b10;
      end
      default: begin
        disp      = 7'b1111111;
        game_over = 1'b0;
        winner    = 2'b00;
      end
    endcase
  end

`ifdef VICTORY_SCORE_EN
  logic [2:0] r_score_l;
  logic [2:0] r_score_r;
  logic       w_enter_l;
  logic       w_enter_r;

  assign w_enter_l = (r_state == PLAY) && (w_next == LWIN);
  assign w_enter_r = (r_state == PLAY) && (w_next == RWIN);

  // Tallies saturate at 7 rather than wrapping back to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_score_l <= 3'd0;
      r_score_r <= 3'd0;
    end else begin
      if (w_enter_l && (r_score_l != 3'd7)) begin
        r_score_l <= r_score_l + 3'd1;
      end
      if (w_enter_r && (r_score_r != 3'd7)) begin
        r_score_r <= r_score_r + 3'd1;
      end
    end
  end

  assign score_l = r_score_l;
  assign score_r = r_score_r;
`endif

endmodule

// File: tb/tb_victory_detect.sv
// tb/tb_victory_detect.sv - bench for victory_detect: winner model plus literal checks
// Exercises score tallies too when VICTORY_SCORE_EN is defined.
module tb_victory_detect;

  logic       clk;
  logic       reset;
  logic       L;
  logic       R;
  logic       NL;
  logic       NR;
  logic       rnd;
  logic [6:0] disp;
  logic       game_over;
  logic [1:0] winner;
  logic [2:0] score_l;
  logic [2:0] score_r;

  int n_checks;
  int n_errors;

  // Model: who has won (0 none, 1 left, 2 right) and the win tallies.
  int m_win;
  int m_sl;
  int m_sr;
  bit m_valid;

  victory_detect dut (
    .clk       (clk),
    .reset     (reset),
    .L         (L),
    .R         (R),
    .NL        (NL),
    .NR        (NR),
`ifdef VICTORY_SCORE_EN
    .rnd       (rnd),
    .score_l   (score_l),
    .score_r   (score_r),
`endif
    .disp      (disp),
    .game_over (game_over),
    .winner    (winner)
  );

`ifndef VICTORY_SCORE_EN
  assign score_l = 3'd0;
  assign score_r = 3'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_for(input int w);
    if (w == 1) return 7'b1111001;
    if (w == 2) return 7'b0100100;
    return 7'b1111111;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_win   = 0;
      m_sl    = 0;
      m_sr    = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_win == 0) begin
        if (L && !R && NL) begin
          m_win = 1;
          if (m_sl < 7) m_sl = m_sl + 1;
        end else if (R && !L && NR) begin
          m_win = 2;
          if (m_sr < 7) m_sr = m_sr + 1;
        end
      end else begin
`ifdef VICTORY_SCORE_EN
        if (rnd) m_win = 0;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_disp", 8'(disp), 8'(digit_for(m_win)));
      chk("model_game_over", 8'(game_over), (m_win != 0) ? 8'd1 : 8'd0);
      chk("model_winner", 8'(winner), 8'(m_win));
`ifdef VICTORY_SCORE_EN
      chk("model_score_l", 8'(score_l), 8'(m_sl));
      chk("model_score_r", 8'(score_r), 8'(m_sr));
`endif
    end
  end

  task automatic cyc(input logic rs, input logic l, input logic r,
                     input logic nl, input logic nr, input logic rn);
    reset = rs;
    L     = l;
    R     = r;
    NL    = nl;
    NR    = nr;
    rnd   = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [6:0] d,
                            input logic go, input logic [1:0] w);
    chk({name, "_disp"}, 8'(disp), 8'(d));
    chk({name, "_game_over"}, 8'(game_over), 8'(go));
    chk({name, "_winner"}, 8'(winner), 8'(w));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_win    = 0;
    m_sl     = 0;
    m_sr     = 0;
    m_valid  = 1'b0;

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("reset", 7'h7F, 1'b0, 2'b00);

    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("lwin", 7'b1111001, 1'b1, 2'b01);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("lwin_hold", 7'b1111001, 1'b1, 2'b01);
    end

    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_out("lwin_sticky", 7'b1111001, 1'b1, 2'b01);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_out("rwin", 7'b0100100, 1'b1, 2'b10);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("rwin_hold", 7'b0100100, 1'b1, 2'b10);
    end

    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("reset_in_rwin", 7'h7F, 1'b0, 2'b00);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      expect_out("both_press", 7'h7F, 1'b0, 2'b00);
    end

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("l_no_nl", 7'h7F, 1'b0, 2'b00);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("r_no_nr", 7'h7F, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_out("l_both_lit", 7'b1111001, 1'b1, 2'b01);

`ifdef VICTORY_SCORE_EN
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("score_reset_l", 8'(score_l), 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("rnd_in_play", 7'h7F, 1'b0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("score_win", 7'b1111001, 1'b1, 2'b01);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("score_rnd", 7'h7F, 1'b0, 2'b00);
    end
    chk("score_l_sat", 8'(score_l), 8'd7);
    chk("score_r_zero", 8'(score_r), 8'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("score_r_one", 8'(score_r), 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("score_l_cleared", 8'(score_l), 8'd0);
    chk("score_r_cleared", 8'(score_r), 8'd0);
`endif

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/victory_detect.md
# victory_detect

Win detector for the two-player tug-of-war game. It samples each player's button-press pulse and the end-of-field light indicators from the playfield. It latches the first legitimate win and drives an active-low 7-segment digit naming the winner. It sits between the button conditioning logic and the HEX display.

## Interface
Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; takes effect on the rising edge of clk while low.
- L  input  1  left-player press; one-cycle pulse from upstream edge detect.
- R  input  1  right-player press; one-cycle pulse.
- NL  input  1  high when the leftmost field light is lit (rope at left edge).
- NR  input  1  high when the rightmost field light is lit (rope at right edge).
- disp  output  7  active-low 7-segment code, bit order {g,f,e,d,c,b,a}.
- game_over  output  1  high while a win is latched.
- winner  output  2  2'b00 none, 2'b01 left, 2'b10 right; 2'b11 never driven.
- rnd  input  1  present only with VICTORY_SCORE_EN; one-cycle next-round pulse.
- score_l, score_r  output  3 each  present only with VICTORY_SCORE_EN; win tallies.

## Operation
- The FSM has three states: PLAY, LWIN and RWIN. Reset state is PLAY.
- PLAY -> LWIN when L & ~R & NL.
- PLAY -> RWIN when R & ~L & NR.
- In PLAY, every other input combination keeps the state in PLAY. This includes L & R together (the presses cancel), and L with NL low.
- LWIN and RWIN are sticky. All inputs are ignored until reset, or until rnd when the macro is enabled.
- NL and NR high together is legal. The rules above still apply unchanged.
- Output decode from state:
  - PLAY: disp = 7'b1111111 (blank), game_over = 0, winner = 00.
  - LWIN: disp = 7'b1111001 ("1"), game_over = 1, winner = 01.
  - RWIN: disp = 7'b0100100 ("2"), game_over = 1, winner = 10.
- Outputs are decoded from registered state only. There is no combinational path from the inputs to the outputs.

## Timing
- Inputs are sampled on the rising edge of clk. A qualifying win condition changes the state at that edge. disp, game_over and winner are valid after that edge, giving 1-cycle latency.
- Reset is evaluated on the edge and takes priority over all inputs.
- Reset low in any state returns to PLAY. After the edge, disp = 7'h7F, game_over = 0 and winner = 00.
- An input pulse arriving in the same cycle as reset is discarded.
- If a win condition is held for many cycles, the state enters the win once and stays there.

## Configuration
- VICTORY_SCORE_EN, when defined, adds the rnd input and the score_l and score_r outputs.
  - On the edge that enters LWIN or RWIN, the corresponding 3-bit score increments by 1. Scores saturate at 7.
  - rnd high in LWIN or RWIN returns the FSM to PLAY on that edge. Scores are kept.
  - rnd is ignored while in PLAY.
  - Reset clears both scores to 0.
  - Entering a win and pressing rnd in the same edge cannot occur, because rnd only acts in win states.
- When VICTORY_SCORE_EN is undefined, those ports and counters do not exist. Wins are cleared only by reset.

## Test plan
- Reset low for 1 cycle, then L=1 and NL=1 -> after the next edge, disp=7'b1111001, winner=01 and game_over=1. These values hold for 5 more cycles with the inputs held.
- Reset low with all inputs 0, then R=1 and NR=1 -> after 1 edge, disp=7'b0100100 and winner=10. The state stays in RWIN for 4 more cycles.
- L=R=NL=NR=1 in PLAY -> disp stays 7'h7F and game_over=0.
- L=1 with NL=0 in PLAY -> no win. R=1 and NR=1 while in LWIN -> disp stays "1".
- Reset low while in RWIN -> disp=7'h7F and winner=00 after the edge.
- VICTORY_SCORE_EN: play 8 left wins, each followed by an rnd pulse -> score_l=7 (saturated) and score_r=0. Reset then gives score_l=0.
